// File: rtl/axis_pkg.sv
// Shared constants and encodings for the AXI-Stream packet transmitter.
package axis_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;

    localparam logic MODE_INC  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/axis_pattern_gen.sv
// Payload pattern source: incrementing counter or 8-bit Fibonacci LFSR.
module axis_pattern_gen
    import axis_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic              mode,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] data
);

    logic              mode_q;
    logic [DATA_W-1:0] nxt;
    logic [DATA_W-1:0] seed_fix;

    // LFSR taps sit in the low byte, so DATA_W must be at least 8
    always_comb begin
        nxt = data + DATA_W'(1);
        if (mode_q == MODE_LFSR)
            nxt = {data[DATA_W-2:0],
                   data[7] ^ data[5] ^ data[4] ^ data[3]};
    end

    // an all-zero LFSR would lock up
    always_comb begin
        seed_fix = seed;
        if (mode == MODE_LFSR && seed == '0)
            seed_fix = DATA_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data   <= '0;
            mode_q <= MODE_INC;
        end else if (load) begin
            data   <= seed_fix;
            mode_q <= mode;
        end else if (advance) begin
            data <= nxt;
        end
    end

endmodule

// File: rtl/axis_pkt_tx.sv
// Packet transmitter: one start -> len+1 pattern beats, then GAP idle cycles.
module axis_pkt_tx
    import axis_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] seed,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic [15:0]       pkt_cnt,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP > 0) ? GAP - 1 : 0);

    state_t            state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx;
    logic [LEN_W-1:0]  idx_nxt;
    logic [GW-1:0]     gap_cnt;
    logic              load;
    logic              advance;

    assign busy    = (state != ST_IDLE);
    assign idx_nxt = idx + LEN_W'(1);
    assign load    = (state == ST_IDLE) && start;
    assign advance = (state == ST_SEND) && m_valid
                   && m_ready && !m_last;

    axis_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .advance (advance),
        .mode    (mode),
        .seed    (seed),
        .data    (m_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            len_q   <= '0;
            idx     <= '0;
            gap_cnt <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            done    <= 1'b0;
            pkt_cnt <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q   <= len;
                        idx     <= '0;
                        m_valid <= 1'b1;
                        m_last  <= (len == '0);
                        state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (m_valid && m_ready) begin
                        if (m_last) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            done    <= 1'b1;
                            pkt_cnt <= pkt_cnt + 16'd1;
                            gap_cnt <= '0;
                            state   <= (GAP == 0) ? ST_IDLE : ST_GAP;
                        end else begin
                            idx    <= idx_nxt;
                            m_last <= (idx_nxt == len_q);
                        end
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
                    if (gap_cnt == GAP_LAST)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pkt_tx.sv
// Randomized directed bench for axis_pkt_tx with a queue-based reference model.
module tb_axis_pkt_tx;

    localparam int DW  = 8;
    localparam int LW  = 8;
    localparam int GAP = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] len;
    logic [DW-1:0] seed;
    logic          mode;
    logic          m_ready;
    logic          busy;
    logic          done;
    logic [15:0]   pkt_cnt;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;

    int checks  = 0;
    int errors  = 0;
    int exp_cnt = 0;
    logic [7:0] exp_q[$];

    axis_pkt_tx #(
        .DATA_W (DW),
        .LEN_W  (LW),
        .GAP    (GAP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .len     (len),
        .seed    (seed),
        .mode    (mode),
        .busy    (busy),
        .done    (done),
        .pkt_cnt (pkt_cnt),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // expected payload: seed+i mod 256, or the LFSR sequence
    function automatic void build(input int n, input int s, input bit md);
        int v;
        exp_q.delete();
        v = (md && s == 0) ? 1 : s;
        for (int i = 0; i < n; i++) begin
            if (md) begin
                exp_q.push_back(8'(v));
                v = ((v * 2) % 256)
                  + (((v >> 7) + (v >> 5) + (v >> 4) + (v >> 3)) % 2);
            end else begin
                exp_q.push_back(8'((s + i) % 256));
            end
        end
    endfunction

    task automatic run_pkt(input int l, input int s, input bit md,
                           input bit rnd_ready, input int stall_at,
                           input bit poke);
        int idx = 0;
        int cyc = 0;
        int stall = 0;
        build(l + 1, s, md);
        @(negedge clk);
        check("idle_before", busy, 0);
        check("valid_idle", m_valid, 0);
        start   = 1'b1;
        len     = LW'(l);
        seed    = DW'(s);
        mode    = md;
        m_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
        len   = LW'($urandom);
        seed  = DW'($urandom);
        mode  = 1'($urandom);
        while (idx <= l) begin
            if (cyc > 3000) begin
                check("cycle_budget", 32'(cyc), 3000);
                break;
            end
            check("valid", m_valid, 1);
            check("data", m_data, exp_q[idx]);
            check("last", m_last, 32'(idx == l));
            check("busy", busy, 1);
            check("done_low", done, 0);
            start = poke && (cyc == 1);
            if (idx == stall_at && stall < 2) begin
                m_ready = 1'b0;
                stall++;
            end else begin
                m_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (m_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        start   = 1'b0;
        m_ready = 1'b1;
        exp_cnt = (exp_cnt + 1) % 65536;
        for (int g = 0; g < GAP; g++) begin
            check("gap_valid", m_valid, 0);
            check("gap_last", m_last, 0);
            check("gap_busy", busy, 1);
            check("done_pulse", done, 32'(g == 0));
            check("pkt_cnt", pkt_cnt, 32'(exp_cnt));
            start = poke && (g == 0);
            seed  = DW'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        check("idle_after", busy, 0);
        check("done_after", done, 0);
        check("valid_after", m_valid, 0);
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        len     = '0;
        seed    = '0;
        mode    = 1'b0;
        m_ready = 1'b0;
        #1;
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_data", m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", pkt_cnt, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_pkt(3, 8'h11, 1'b0, 1'b0, -1, 1'b0);
        run_pkt(3, 8'hAA, 1'b0, 1'b0, 2, 1'b0);
        run_pkt(3, 8'hFE, 1'b0, 1'b0, -1, 1'b0);
        run_pkt(5, int'($urandom_range(0, 255)), 1'b0, 1'b1, -1, 1'b1);
        run_pkt(3, 8'h00, 1'b1, 1'b0, -1, 1'b0);
        run_pkt(0, 8'h5C, 1'b0, 1'b0, -1, 1'b0);
        run_pkt(0, 8'h00, 1'b1, 1'b1, -1, 1'b1);
        run_pkt(255, int'($urandom_range(0, 255)), 1'b1, 1'b1, -1, 1'b1);
        for (int k = 0; k < 12; k++)
            run_pkt(int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 255)),
                    1'($urandom), 1'b1,
                    int'($urandom_range(0, 4)) - 1,
                    1'($urandom));

        @(negedge clk);
        start   = 1'b1;
        len     = 8'd7;
        seed    = 8'h33;
        mode    = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_b0", m_data, 8'h33);
        @(negedge clk);
        check("rst_b1", m_data, 8'h34);
        @(negedge clk);
        check("rst_b2", m_data, 8'h35);
        #2 reset = 1'b0;
        #1;
        exp_cnt = 0;
        check("mid_valid", m_valid, 0);
        check("mid_last", m_last, 0);
        check("mid_data", m_data, 0);
        check("mid_busy", busy, 0);
        check("mid_cnt", pkt_cnt, 0);
        repeat (3) begin
            @(negedge clk);
            check("mid_done", done, 0);
            check("mid_cnt_hold", pkt_cnt, 0);
        end
        reset = 1'b1;
        run_pkt(3, 8'h50, 1'b0, 1'b0, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_pkt_tx.md
AXIS_PKT_TX -- requirements
Module: axis_pkt_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning stream byte width.
REQ-002 SHALL have parameter LEN_W, default 8, meaning packet-length field width (beats = len+1, so 1..256).
REQ-003 SHALL have parameter GAP, default 2, meaning idle cycles enforced after each packet.
REQ-004 SHALL have ports, one per line:
 clk  input  1  single clock; all logic on rising edge.
 reset  input  1  asynchronous, active-low reset.
 start  input  1  request to send one packet.
 len  input  LEN_W  packet beats minus one.
 seed  input  DATA_W  first data byte / LFSR seed.
 mode  input  1  0 = incrementing pattern, 1 = LFSR pattern.
 busy  output  1  high whenever state is not IDLE.
 done  output  1  one-cycle pulse after the last beat transfers.
 pkt_cnt  output  16  packets completed; wraps at 16'hFFFF.
 m_data  output  DATA_W  stream data.
 m_valid  output  1  stream valid.
 m_last  output  1  final beat of packet.
 m_ready  input  1  downstream ready.

Function
REQ-005 SHALL implement FSM states IDLE, SEND, GAP_WAIT.
REQ-006 SHALL accept start only in IDLE; start while busy is ignored, with no latching or queuing.
REQ-007 SHALL latch len, seed and mode on the accepting edge, then enter SEND with m_valid=1 and m_data=seed on the next cycle (1-cycle latency).
REQ-008 SHALL count a beat as transferred only on a clock edge where m_valid&&m_ready.
REQ-009 SHALL hold m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-010 SHALL keep m_valid high continuously from the first to the last beat (no bubbles).
REQ-011 SHALL drive m_last=1 exactly when beat index equals the latched len.
REQ-012 Incrementing mode SHALL produce data = seed + index, modulo 2^DATA_W (wrap-around, no saturation).
REQ-013 LFSR mode SHALL produce Fibonacci left shift, new bit0 = b7^b5^b4^b3; seed 0 SHALL be replaced by 8'h01.
REQ-014 On the last-beat transfer, the block SHALL pulse done for one cycle, increment pkt_cnt, and drop m_valid/m_last on the next cycle.
REQ-015 The block SHALL enter GAP_WAIT for exactly GAP cycles with m_valid=0, then return to IDLE; GAP=0 SHALL go straight to IDLE.
REQ-016 len=0 SHALL send a single beat with m_last=1.
REQ-017 m_ready high while m_valid=0 SHALL have no effect.

Reset
REQ-018 reset low SHALL immediately force: state IDLE; m_valid=0; m_last=0; m_data=0; busy=0; done=0; pkt_cnt=0; beat index 0.
REQ-019 reset mid-packet SHALL abandon the packet: no done pulse and no pkt_cnt increment; the next accepted start begins a fresh packet.

Structure
REQ-020 A shared package axis_pkg SHALL hold DATA_W/LEN_W defaults, mode constants (MODE_INC, MODE_LFSR) and the FSM state encoding.
REQ-021 The pattern generator SHALL be the sub-module axis_pattern_gen (load/advance/mode, combinational next value, registered output).

Verification
REQ-022 len=3, seed=8'h11, mode=0, m_ready=1 -> beats 11,12,13,14; m_last only on 14; done one cycle; pkt_cnt=1.
REQ-023 len=3, seed=8'hAA, m_ready=0 for 2 cycles while 8'hAC is presented -> m_data held at AC, m_valid held high; exactly 4 beats AA..AD transfer.
REQ-024 len=3, seed=8'hFE -> beats FE,FF,00,01 (wrap).
REQ-025 start pulsed during SEND and during GAP_WAIT -> ignored; GAP=2 gives m_valid=0 for 2 cycles after the last beat, then IDLE.
REQ-026 mode=1, seed=0, len=3 -> beats 01,02,04,08.
REQ-027 reset low during beat 2 of len=7 -> m_valid=0 asynchronously; pkt_cnt=0, no done; after release, start with seed=8'h50 -> first beat 50.
